// File: rtl/bpi_flash_responder.sv
// rtl/bpi_flash_responder.sv - x16 NOR flash responder on the BPI bus, oversampled by clk
// Optional per-block locking is enabled by defining BPI_RESP_LOCK_EN.
module bpi_flash_responder #(
  parameter int          MEM_AW      = 10,
  parameter int          BLOCK_AW    = 6,
  parameter int          PROG_CYCLES = 16,
  parameter logic [15:0] MFR_ID      = 16'h0089,
  parameter logic [15:0] DEV_ID      = 16'h8962
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [24:0] bpi_addr,
  input  logic [15:0] bpi_dq_i,
  output logic [15:0] bpi_dq_o,
  output logic        bpi_dq_oe,
  input  logic        bpi_ce_n,
  input  logic        bpi_oe_n,
  input  logic        bpi_we_n,
  input  logic        bpi_adv_n,
  output logic        busy,
  output logic [7:0]  status
);

  localparam int DEPTH = 1 << MEM_AW;
  localparam int BW    = (MEM_AW > BLOCK_AW) ? (MEM_AW - BLOCK_AW) : 1;
  localparam int NBLK  = 1 << BW;
  localparam int CW    = $clog2(PROG_CYCLES + 1);

  typedef enum logic [2:0] {
    READ_ARRAY, READ_STATUS, READ_ID, PROG_SETUP,
    ERASE_SETUP, BUSY_PROG, BUSY_ERASE, LOCK_SETUP
  } mode_t;

  mode_t mode, mode_nx;

  logic ce_s1, oe_s1, we_s1, adv_s1;
  logic ce_s2, oe_s2, we_s2, adv_s2;
  logic ce_s3, we_s3;
  logic [MEM_AW-1:0] addr_s1, addr_s2, addr_lat;
  logic [15:0]       dq_s1, dq_s2;

  logic [MEM_AW-1:0]   eff_addr;
  logic [BW-1:0]       blk;
  logic [BLOCK_AW-1:0] offset;
  logic [7:0]          cmd;
  logic                we_rise, rd, lock_hit;

  logic [CW-1:0]       cnt;
  logic [BLOCK_AW-1:0] ecnt;
  logic [BW-1:0]       erase_blk;
  logic [MEM_AW-1:0]   prog_addr;
  logic [15:0]         prog_data;
  logic [2:0]          err;   // {SR5, SR4, SR1}

  logic                mem_we;
  logic [MEM_AW-1:0]   mem_waddr;
  logic [15:0]         mem_wdata;
  logic [15:0]         rd_data;

  // Erased contents at configuration; deliberately untouched by rst_n.
  logic [15:0] mem [DEPTH] = '{default: 16'hFFFF};

  logic unused_bits;
  assign unused_bits = ^bpi_addr[24:MEM_AW];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      {ce_s1, oe_s1, we_s1, adv_s1} <= 4'hF;
      {ce_s2, oe_s2, we_s2, adv_s2} <= 4'hF;
      {ce_s3, we_s3}                <= 2'b11;
      addr_s1  <= '0;
      addr_s2  <= '0;
      addr_lat <= '0;
      dq_s1    <= '0;
      dq_s2    <= '0;
    end else begin
      {ce_s1, oe_s1, we_s1, adv_s1} <= {bpi_ce_n, bpi_oe_n, bpi_we_n, bpi_adv_n};
      {ce_s2, oe_s2, we_s2, adv_s2} <= {ce_s1, oe_s1, we_s1, adv_s1};
      {ce_s3, we_s3}                <= {ce_s2, we_s2};
      addr_s1 <= bpi_addr[MEM_AW-1:0];
      addr_s2 <= addr_s1;
      dq_s1   <= bpi_dq_i;
      dq_s2   <= dq_s1;
      if (!adv_s2) addr_lat <= addr_s2;
    end
  end

  // The live stage-2 address bypasses the latch so address-to-data stays at 3 clk.
  assign eff_addr = adv_s2 ? addr_lat : addr_s2;
  assign blk      = BW'(eff_addr >> BLOCK_AW);
  assign offset   = eff_addr[BLOCK_AW-1:0];
  assign cmd      = dq_s2[7:0];
  assign we_rise  = we_s2 & ~we_s3 & ~ce_s3;
  assign rd       = ~ce_s2 & ~oe_s2 & we_s2;

`ifdef BPI_RESP_LOCK_EN
  logic [NBLK-1:0] lock;
  assign lock_hit = lock[blk];
`else
  assign lock_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) mode <= READ_ARRAY;
    else        mode <= mode_nx;
  end

  always_comb begin
    mode_nx = mode;
    case (mode)
      READ_ARRAY, READ_STATUS, READ_ID: begin
        if (we_rise) begin
          case (cmd)
            8'hFF:        mode_nx = READ_ARRAY;
            8'h70:        mode_nx = READ_STATUS;
            8'h90:        mode_nx = READ_ID;
            8'h40, 8'h10: mode_nx = PROG_SETUP;
            8'h20:        mode_nx = ERASE_SETUP;
`ifdef BPI_RESP_LOCK_EN
            8'h60:        mode_nx = LOCK_SETUP;
`endif
            default:      mode_nx = mode;
          endcase
        end
      end
      PROG_SETUP:
        if (we_rise) mode_nx = lock_hit ? READ_STATUS : BUSY_PROG;
      ERASE_SETUP:
        if (we_rise) mode_nx = (cmd == 8'hD0 && !lock_hit) ? BUSY_ERASE : READ_STATUS;
      LOCK_SETUP:
        if (we_rise) mode_nx = READ_STATUS;
      BUSY_PROG:
        if (cnt == CW'(1)) mode_nx = READ_STATUS;
      BUSY_ERASE:
        if (&ecnt) mode_nx = READ_STATUS;
      default: mode_nx = READ_ARRAY;
    endcase
  end

  always_comb begin
    busy      = (mode == BUSY_PROG) || (mode == BUSY_ERASE);
    status    = {~busy, 1'b0, err[2], err[1], 2'b00, err[0], 1'b0};
    mem_we    = 1'b0;
    mem_waddr = prog_addr;
    mem_wdata = mem[prog_addr] & prog_data;
    if (mode == BUSY_PROG) begin
      mem_we = (cnt == CW'(1));
    end else if (mode == BUSY_ERASE) begin
      mem_we    = 1'b1;
      mem_waddr = MEM_AW'({erase_blk, ecnt});
      mem_wdata = 16'hFFFF;
    end
    rd_data = {8'h00, status};
    if (mode == READ_ARRAY) begin
      rd_data = mem[eff_addr];
    end else if (mode == READ_ID) begin
      if (offset == BLOCK_AW'(0))      rd_data = MFR_ID;
      else if (offset == BLOCK_AW'(1)) rd_data = DEV_ID;
`ifdef BPI_RESP_LOCK_EN
      else if (offset == BLOCK_AW'(2)) rd_data = {15'b0, lock_hit};
`endif
      else                             rd_data = 16'h0000;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt       <= '0;
      ecnt      <= '0;
      erase_blk <= '0;
      prog_addr <= '0;
      prog_data <= '0;
      err       <= '0;
      bpi_dq_oe <= 1'b0;
      bpi_dq_o  <= '0;
`ifdef BPI_RESP_LOCK_EN
      lock      <= '1;
`endif
    end else begin
      bpi_dq_oe <= rd;
      bpi_dq_o  <= rd_data;
      case (mode)
        READ_ARRAY, READ_STATUS, READ_ID:
          if (we_rise && cmd == 8'h50) err <= '0;
        PROG_SETUP:
          if (we_rise) begin
            if (lock_hit) begin
              err <= err | 3'b011;
            end else begin
              prog_addr <= eff_addr;
              prog_data <= dq_s2;
              cnt       <= CW'(PROG_CYCLES);
            end
          end
        ERASE_SETUP:
          if (we_rise) begin
            if (cmd != 8'hD0) begin
              err <= err | 3'b110;
            end else if (lock_hit) begin
              err <= err | 3'b101;
            end else begin
              erase_blk <= blk;
              ecnt      <= '0;
            end
          end
        LOCK_SETUP: begin
`ifdef BPI_RESP_LOCK_EN
          if (we_rise) begin
            if (cmd == 8'h01)      lock[blk] <= 1'b1;
            else if (cmd == 8'hD0) lock[blk] <= 1'b0;
            else                   err <= err | 3'b110;
          end
`endif
        end
        BUSY_PROG:  cnt  <= cnt - 1'b1;
        BUSY_ERASE: ecnt <= ecnt + 1'b1;
        default: ;
      endcase
    end
  end

  // Gating with rst_n makes a reset during busy stop array writes on that same edge.
  always_ff @(posedge clk) begin
    if (rst_n && mem_we) mem[mem_waddr] <= mem_wdata;
  end

endmodule
